// File: rtl/pipe_trace_pkg.sv
// Shared types and helpers for the pipeline trace buffer.
// Entry layout, MSB first: {stamp, pc, per-stage valid bits, per-stage instruction words}.
package pipe_trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_POST = 3'd2,
    ST_DONE = 3'd3,
    ST_READ = 3'd4
  } trace_state_e;

  typedef enum logic [1:0] {
    TRIG_MANUAL = 2'd0,
    TRIG_PC     = 2'd1,
    TRIG_INSTR  = 2'd2,
    TRIG_RSVD   = 2'd3
  } trig_mode_e;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_STAGES  = 5;
  localparam int DEF_STAMP_W = 16;

  // Entry view for the default 5-stage RV32 configuration.
  typedef struct packed {
    logic [DEF_STAMP_W-1:0]          stamp;
    logic [DEF_XLEN-1:0]             pc;
    logic [DEF_STAGES-1:0]           valid;
    logic [DEF_STAGES-1:0][31:0]     instr;
  } trace_entry_t;

  function automatic int entry_w(input int stamp_w, input int xlen, input int num_stages);
    return stamp_w + xlen + num_stages * 33;
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// Simple dual-port trace storage: synchronous write, registered read, contents not reset.
module trace_ram
  import pipe_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pipe_trace_buffer.sv
// Circular trace capture of PC and per-stage instructions; freezes after a trigger
// plus POST_TRIG entries, then drains oldest-first over a valid/ready port.
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 5,
  parameter int DEPTH      = 16,
  parameter int POST_TRIG  = 8,
  parameter int STAMP_W    = 16
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          trace_en,
  input  logic [XLEN-1:0]                               pc_in,
  input  logic [NUM_STAGES*32-1:0]                      stage_instr,
  input  logic [NUM_STAGES-1:0]                         stage_valid,
  input  logic [1:0]                                    trig_mode,
  input  logic [XLEN-1:0]                               trig_value,
  input  logic                                          trig_manual,
  input  logic                                          arm,
  output logic                                          rd_valid,
  input  logic                                          rd_ready,
  output logic [entry_w(STAMP_W, XLEN, NUM_STAGES)-1:0] rd_data,
  output logic                                          rd_last,
  output logic [2:0]                                    state_o,
  output logic [$clog2(DEPTH):0]                        entry_count
);

  localparam int EW = entry_w(STAMP_W, XLEN, NUM_STAGES);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] POST_LAST = AW'((POST_TRIG == 0) ? 0 : POST_TRIG - 1);
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE       = (AW+1)'(1);

  trace_state_e        state_q, state_d;
  logic [STAMP_W-1:0]  stamp_q;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       post_q, post_d;
  logic [AW:0]         count_q, count_d;
  logic [NUM_STAGES-1:0] instr_hit;
  logic                trig_hit, wr_en, rd_en, xfer;
  logic [AW-1:0]       raddr;
  logic [EW-1:0]       wr_data, ram_rdata;

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_match
    assign instr_hit[gi] = stage_valid[gi] && (stage_instr[32*gi +: 32] == trig_value[31:0]);
  end

  always_comb begin
    case (trig_mode_e'(trig_mode))
      TRIG_PC:    trig_hit = trig_manual || (pc_in == trig_value);
      TRIG_INSTR: trig_hit = trig_manual || (|instr_hit);
      default:    trig_hit = trig_manual;
    endcase
  end

  assign wr_data     = {stamp_q, pc_in, stage_valid, stage_instr};
  assign rd_valid    = (state_q == ST_READ);
  assign xfer        = rd_valid && rd_ready;
  assign rd_last     = rd_valid && (count_q == ONE);
  assign rd_data     = rd_valid ? ram_rdata : '0;
  assign state_o     = state_q;
  assign entry_count = count_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    post_d   = post_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    raddr    = rd_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d  = ST_PRE;
          wr_ptr_d = '0;
          count_d  = '0;
          post_d   = '0;
        end
      end
      ST_PRE, ST_POST: begin
        if (trace_en) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (count_q != FULL) count_d = count_q + ONE;
          if (state_q == ST_PRE) begin
            if (trig_hit) state_d = (POST_TRIG == 0) ? ST_DONE : ST_POST;
          end else begin
            post_d = post_q + AW'(1);
            if (post_q == POST_LAST) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Prefetch the oldest entry so rd_data is valid on the first READ cycle.
        rd_ptr_d = wr_ptr_q - count_q[AW-1:0];
        raddr    = rd_ptr_d;
        rd_en    = 1'b1;
        state_d  = ST_READ;
      end
      ST_READ: begin
        rd_en = 1'b1;
        if (xfer) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          count_d  = count_q - ONE;
          raddr    = rd_ptr_d;
          if (count_q == ONE) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      stamp_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      post_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      stamp_q  <= stamp_q + STAMP_W'(1);
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      post_q   <= post_d;
      count_q  <= count_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

endmodule
